// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM update scheduler: register map, channel count
// and the configuration payload carried by the shadow and active register sets.
package pwm_cfg_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_MAX       = ADDR_CTRL;

  localparam int unsigned CTRL_SYNC_EN_BIT = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [CNT_W-1:0]  duty;
  } pwm_cfg_t;

  // Returns cfg with the byte selected by addr replaced; non-config addresses leave it unchanged.
  function automatic pwm_cfg_t cfg_write(pwm_cfg_t cfg, logic [ADDR_W-1:0] addr,
                                         logic [DATA_W-1:0] data);
    pwm_cfg_t r;
    r = cfg;
    case (addr)
      ADDR_EN_OUT_LO: r.en_out[7:0]  = data;
      ADDR_EN_OUT_HI: r.en_out[15:8] = data;
      ADDR_EN_PWM_LO: r.en_pwm[7:0]  = data;
      ADDR_EN_PWM_HI: r.en_pwm[15:8] = data;
      ADDR_DUTY:      r.duty         = data;
      default:        r = cfg;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Prescaler plus 8-bit PWM period counter; flags the last step of each period
// and pulses period_start on the first clock of the next one.
module pwm_period_timer
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned PRESCALE = 13
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             boundary_c,
  output logic             period_start
);

  localparam int unsigned     PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic             tick_c;

  assign tick_c     = (psc == PSC_LAST);
  assign boundary_c = tick_c && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      psc          <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      psc          <= tick_c ? '0 : psc + 1'b1;
      if (tick_c) pwm_cnt <= pwm_cnt + 1'b1;
      period_start <= boundary_c;
    end
  end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Shadow/active configuration registers with period-aligned atomic commit,
// and the registered PWM/enable pin mapping.
module pwm_update_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned PRESCALE = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic [NUM_CH-1:0] en_out_act,
  output logic [NUM_CH-1:0] en_pwm_act,
  output logic [CNT_W-1:0]  duty_act,
  output logic [CNT_W-1:0]  pwm_cnt,
  output logic              period_start,
  output logic              commit_done,
  output logic              pending,
  output logic [NUM_CH-1:0] pins
);

  pwm_cfg_t          cfg_sh, cfg_act, cfg_sh_nxt, cfg_act_nxt;
  logic              sync_en, pending_nxt;
  logic              wr_cfg_c, wr_ctrl_c, wr_bad_c, commit_c, boundary_c, level_c;
  logic [NUM_CH-1:0] pins_nxt;

  pwm_period_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .boundary_c   (boundary_c),
    .period_start (period_start)
  );

  assign en_out_act = cfg_act.en_out;
  assign en_pwm_act = cfg_act.en_pwm;
  assign duty_act   = cfg_act.duty;

  // Commit takes the pre-write shadow; an unsynchronised write then lands on both sets.
  always_comb begin
    wr_cfg_c    = wr_valid && (wr_addr < ADDR_CTRL);
    wr_ctrl_c   = wr_valid && (wr_addr == ADDR_CTRL);
    wr_bad_c    = wr_valid && (wr_addr > ADDR_MAX);
    commit_c    = pending && (boundary_c || !sync_en);
    cfg_sh_nxt  = wr_cfg_c ? cfg_write(cfg_sh, wr_addr, wr_data) : cfg_sh;
    cfg_act_nxt = commit_c ? cfg_sh : cfg_act;
    if (wr_cfg_c && !sync_en) cfg_act_nxt = cfg_write(cfg_act_nxt, wr_addr, wr_data);
    pending_nxt = pending;
    if (commit_c) pending_nxt = 1'b0;
    if (wr_cfg_c && sync_en) pending_nxt = 1'b1;
    level_c     = (cfg_act.duty == '1) || (pwm_cnt < cfg_act.duty);
    pins_nxt    = cfg_act.en_out & (~cfg_act.en_pwm | {NUM_CH{level_c}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_sh      <= '0;
      cfg_act     <= '0;
      sync_en     <= 1'b1;
      pending     <= 1'b0;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
      pins        <= '0;
    end else begin
      cfg_sh      <= cfg_sh_nxt;
      cfg_act     <= cfg_act_nxt;
      pending     <= pending_nxt;
      wr_err      <= wr_bad_c;
      commit_done <= commit_c;
      pins        <= pins_nxt;
      if (wr_ctrl_c) sync_en <= wr_data[CTRL_SYNC_EN_BIT];
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler with PRESCALE=1 (one counter step per clock).
module tb_pwm_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_err;
  logic [15:0] en_out_act, en_pwm_act, pins;
  logic [7:0]  duty_act, pwm_cnt;
  logic        period_start, commit_done, pending;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  pwm_update_scheduler #(.PRESCALE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .en_out_act   (en_out_act),
    .en_pwm_act   (en_pwm_act),
    .duty_act     (duty_act),
    .pwm_cnt      (pwm_cnt),
    .period_start (period_start),
    .commit_done  (commit_done),
    .pending      (pending),
    .pins         (pins)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; cyc counts edges since the last reset edge, so pwm_cnt should be cyc%256.
  task automatic step();
    bit r;
    r = rst;
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic goto_cnt(input int v);
    while ((cyc % 256) != v) step();
    chk("goto_cnt", 32'(pwm_cnt), 32'(v));
  endtask

  function automatic logic [15:0] pin_model(input int cnt, input logic [15:0] eo,
                                            input logic [15:0] ep, input logic [7:0] d);
    logic lvl;
    lvl = (d == 8'hFF) || (cnt < int'(d));
    return eo & (~ep | {16{lvl}});
  endfunction

  // Checks a full period of pins; entered at pwm_cnt==1, pins reflect the previous count.
  task automatic scan_period(input string tag, input logic [15:0] eo, input logic [15:0] ep,
                             input logic [7:0] d);
    for (int i = 0; i < 256; i++) begin
      chk(tag, 32'(pins), 32'(pin_model(i, eo, ep, d)));
      step();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_err"}, 32'(wr_err), 0);
    chk({tag, "_en_out"}, 32'(en_out_act), 0);
    chk({tag, "_en_pwm"}, 32'(en_pwm_act), 0);
    chk({tag, "_duty"}, 32'(duty_act), 0);
    chk({tag, "_cnt"}, 32'(pwm_cnt), 0);
    chk({tag, "_pstart"}, 32'(period_start), 0);
    chk({tag, "_commit"}, 32'(commit_done), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_pins"}, 32'(pins), 0);
  endtask

  initial begin
    // Reset and free-running counter
    step();
    step();
    chk_reset_state("rst");
    rst = 1'b0;
    for (int i = 0; i <= 256; i++) begin
      chk("free_cnt", 32'(pwm_cnt), 32'(cyc % 256));
      chk("free_pstart", 32'(period_start), 32'((cyc % 256 == 0) && (cyc > 0)));
      step();
    end

    // Synchronised writes mid-period wait for the boundary
    goto_cnt(100);
    wr(7'h00, 8'hFF);
    wr(7'h02, 8'hFF);
    wr(7'h04, 8'h80);
    chk("sync_pending", 32'(pending), 1);
    chk("sync_hold_en_out", 32'(en_out_act), 0);
    chk("sync_hold_duty", 32'(duty_act), 0);
    goto_cnt(255);
    chk("pre_bnd_commit", 32'(commit_done), 0);
    chk("pre_bnd_en_out", 32'(en_out_act), 0);
    step();
    chk("bnd_commit", 32'(commit_done), 1);
    chk("bnd_pstart", 32'(period_start), 1);
    chk("bnd_en_out", 32'(en_out_act), 32'h00FF);
    chk("bnd_en_pwm", 32'(en_pwm_act), 32'h00FF);
    chk("bnd_duty", 32'(duty_act), 32'h80);
    chk("bnd_pending", 32'(pending), 0);
    chk("bnd_pins_lag", 32'(pins), 0);
    step();
    chk("post_bnd_commit", 32'(commit_done), 0);
    scan_period("pins_d80", 16'h00FF, 16'h00FF, 8'h80);

    // Duty 0xFF is 100%, duty 0x00 is 0%
    wr(7'h04, 8'hFF);
    goto_cnt(255);
    step();
    chk("dff_duty", 32'(duty_act), 32'hFF);
    step();
    scan_period("pins_dff", 16'h00FF, 16'h00FF, 8'hFF);
    wr(7'h04, 8'h00);
    goto_cnt(255);
    step();
    chk("d00_duty", 32'(duty_act), 0);
    step();
    scan_period("pins_d00", 16'h00FF, 16'h00FF, 8'h00);

    // Write landing on the boundary edge: old shadow commits, new byte stays pending
    wr(7'h04, 8'h20);
    goto_cnt(255);
    wr(7'h04, 8'h40);
    chk("wb_commit", 32'(commit_done), 1);
    chk("wb_duty_old", 32'(duty_act), 32'h20);
    chk("wb_pending", 32'(pending), 1);
    goto_cnt(255);
    step();
    chk("wb2_commit", 32'(commit_done), 1);
    chk("wb2_duty_new", 32'(duty_act), 32'h40);
    chk("wb2_pending", 32'(pending), 0);

    // Clearing sync_en flushes on the following cycle, then writes are immediate
    step();
    wr(7'h00, 8'h0F);
    chk("flush_pending0", 32'(pending), 1);
    wr(7'h05, 8'h00);
    chk("flush_wait_pending", 32'(pending), 1);
    chk("flush_wait_en_out", 32'(en_out_act), 32'h00FF);
    chk("flush_wait_commit", 32'(commit_done), 0);
    step();
    chk("flush_commit", 32'(commit_done), 1);
    chk("flush_en_out", 32'(en_out_act), 32'h000F);
    chk("flush_pending", 32'(pending), 0);
    wr(7'h01, 8'h0F);
    chk("async_en_out", 32'(en_out_act), 32'h0F0F);
    chk("async_pending", 32'(pending), 0);
    chk("async_commit", 32'(commit_done), 0);
    step();
    chk("async_pins_hi", 32'(pins[15:8]), 32'h0F);

    // Bad address: error pulse, nothing changes
    wr(7'h06, 8'hAA);
    chk("err_pulse", 32'(wr_err), 1);
    chk("err_en_out", 32'(en_out_act), 32'h0F0F);
    chk("err_en_pwm", 32'(en_pwm_act), 32'h00FF);
    chk("err_duty", 32'(duty_act), 32'h40);
    chk("err_pending", 32'(pending), 0);
    step();
    chk("err_clear", 32'(wr_err), 0);

    // Reset mid-period with pending data
    wr(7'h05, 8'h01);
    wr(7'h04, 8'h99);
    chk("pre_rst_pending", 32'(pending), 1);
    chk("pre_rst_duty", 32'(duty_act), 32'h40);
    rst = 1'b1;
    step();
    chk_reset_state("mid_rst");
    rst = 1'b0;
    wr(7'h00, 8'h01);
    chk("rst_sync_pending", 32'(pending), 1);
    chk("rst_sync_en_out", 32'(en_out_act), 0);
    goto_cnt(255);
    step();
    chk("rst_commit", 32'(commit_done), 1);
    chk("rst_en_out", 32'(en_out_act), 32'h0001);
    chk("rst_lost_duty", 32'(duty_act), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
